// File: rtl/timer_counter.sv
// Memory-mapped 32-bit programmable down-counter with CTRL/PRESET/COUNT registers.
// One-shot mode holds irq until software acknowledges it; auto-reload mode pulses irq once per period.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;
  localparam logic [1:0] MODE_RELOAD = 2'd1;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q, irq_d;

  logic        wrCtrl;
  logic        wrPreset;
  logic        setFlag;
  logic        reloadAck;
  logic        unusedAddrBits;

  assign wrCtrl         = we && (addr[3:2] == ADDR_CTRL);
  assign wrPreset       = we && (addr[3:2] == ADDR_PRESET);
  assign unusedAddrBits = ^addr[31:4];

  // Counter FSM first, then CPU writes layered on top so a CTRL write beats the INT-state EN clear.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    flag_d    = flag_q;
    setFlag   = 1'b0;
    reloadAck = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          setFlag = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_q == MODE_RELOAD) begin
          reloadAck = 1'b1;
          state_d   = ST_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wrCtrl) begin
      en_d   = wdata[0];
      mode_d = wdata[2:1];
      im_d   = wdata[3];
    end
    if (wrPreset) begin
      preset_d = wdata;
    end

    // Expiry in the same cycle as an acknowledging write must not lose the interrupt.
    if (setFlag) begin
      flag_d = 1'b1;
    end else if (wrCtrl || wrPreset || reloadAck) begin
      flag_d = 1'b0;
    end
  end

  assign irq_d = flag_d & im_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      ADDR_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      ADDR_RSVD:   rdata = 32'd0;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed vector table, corner-case sequences,
// and randomized bus traffic compared against a behavioural model of the timer.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int vecCount  = 0;
  int missCount = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: phase of the timer plus the architectural registers.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COUNT = 2, PH_INT = 3;
  int          mPhase;
  logic        mEn, mIm, mFlag, mIrq;
  logic [1:0]  mMode;
  logic [31:0] mPreset, mCount;

  task automatic modelReset();
    mPhase = PH_IDLE; mEn = 1'b0; mIm = 1'b0; mFlag = 1'b0; mIrq = 1'b0;
    mMode = 2'd0; mPreset = 32'd0; mCount = 32'd0;
  endtask

  task automatic modelEdge(input logic w, input logic [1:0] a, input logic [31:0] d);
    int          nPhase  = mPhase;
    logic [31:0] nCount  = mCount;
    logic        nEn     = mEn;
    logic        expired = 1'b0;
    logic        ackPulse = 1'b0;
    if (mPhase == PH_IDLE) begin
      if (mEn) nPhase = PH_LOAD;
    end else if (mPhase == PH_LOAD) begin
      nCount = mPreset;
      nPhase = PH_COUNT;
    end else if (mPhase == PH_COUNT) begin
      if (!mEn) nPhase = PH_IDLE;
      else if (mCount > 32'd1) nCount = mCount - 32'd1;
      else begin
        nCount  = 32'd0;
        expired = 1'b1;
        nPhase  = PH_INT;
      end
    end else begin
      if (mMode == 2'd1) begin
        ackPulse = 1'b1;
        nPhase   = PH_LOAD;
      end else begin
        nEn    = 1'b0;
        nPhase = PH_IDLE;
      end
    end
    if (w && a == 2'd0) begin
      nEn   = d[0];
      mMode = d[2:1];
      mIm   = d[3];
    end
    if (w && a == 2'd1) mPreset = d;
    if (expired) mFlag = 1'b1;
    else if (ackPulse || (w && a <= 2'd1)) mFlag = 1'b0;
    mPhase = nPhase;
    mCount = nCount;
    mEn    = nEn;
    mIrq   = mFlag & mIm;
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, mIm, mMode, mEn};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
    we        = w;
    addr      = '0;
    addr[3:2] = a;
    wdata     = d;
    @(posedge clk);
    modelEdge(w, a, d);
    #1;
    we = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] v);
    addr      = '0;
    addr[3:2] = a;
    #1;
    v = rdata;
  endtask

  task automatic checkReg(input string name, input logic [1:0] a, input logic [31:0] expected);
    logic [31:0] v;
    readReg(a, v);
    checkOutput(name, v, expected);
  endtask

  task automatic checkIrq(input string name, input logic expected);
    checkOutput(name, {31'd0, irq}, {31'd0, expected});
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    modelReset();
  endtask

  typedef struct packed {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [1:0]  ra;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [1:0] ra, input logic [31:0] expRd, input logic expIrq);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.ra = ra; v.expRd = expRd; v.expIrq = expIrq;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rv;
    logic [1:0]  ra;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] reloadCount [16];

    reset = 1'b1; we = 1'b0; addr = '0; wdata = 32'd0;
    modelReset();
    #12;
    reset = 1'b0;
    checkIrq("reset irq", 1'b0);
    for (int i = 0; i < 4; i++) checkReg($sformatf("reset read addr%0d", i), 2'(i), 32'd0);

    // One-shot with PRESET=5: count visible from edge 2, irq at edge 7 and held.
    addVec(1, 2'd1, 32'd5,         2'd1, 32'd5, 0);
    addVec(1, 2'd0, 32'hFFFF_FFF9, 2'd0, 32'h9, 0);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd0, 0);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd5, 0);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd4, 0);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd3, 0);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd2, 0);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd1, 0);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd0, 1);
    addVec(0, 2'd0, 32'd0, 2'd0, 32'h8, 1);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd0, 1);
    addVec(1, 2'd0, 32'h8,         2'd0, 32'h8, 0);
    addVec(1, 2'd2, 32'h1234,      2'd2, 32'd0, 0);
    addVec(1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'd0, 0);
    addVec(0, 2'd0, 32'd0, 2'd1, 32'd5, 0);
    // Auto-reload with PRESET=3: irq pulses at edges 5, 10, 15.
    addVec(1, 2'd1, 32'd3, 2'd1, 32'd3, 0);
    addVec(1, 2'd0, 32'hB, 2'd0, 32'hB, 0);
    reloadCount = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2,
                    32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    for (int e = 1; e <= 16; e++)
      addVec(0, 2'd0, 32'd0, 2'd2, reloadCount[e-1], (e % 5) == 0);
    addVec(1, 2'd0, 32'h0, 2'd2, 32'd3, 0);
    addVec(0, 2'd0, 32'd0, 2'd2, 32'd3, 0);
    addVec(0, 2'd0, 32'd0, 2'd0, 32'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].w, vecs[i].a, vecs[i].d);
      readReg(vecs[i].ra, rv);
      checkOutput($sformatf("vec%0d rdata", i), rv, vecs[i].expRd);
      checkIrq($sformatf("vec%0d irq", i), vecs[i].expIrq);
    end

    // Asynchronous reset mid-cycle while auto-reload is counting.
    doReset();
    writeReg(2'd1, 32'd2);
    writeReg(2'd0, 32'hB);
    step(4);
    checkIrq("arst pre irq", 1'b1);
    step(2);
    checkReg("arst pre count", 2'd2, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkIrq("arst irq", 1'b0);
    checkReg("arst ctrl", 2'd0, 32'd0);
    checkReg("arst preset", 2'd1, 32'd0);
    checkReg("arst count", 2'd2, 32'd0);
    reset = 1'b0;
    modelReset();
    step(5);
    checkIrq("arst no pending irq", 1'b0);
    checkReg("arst idle count", 2'd2, 32'd0);

    // Masked interrupt, then enabling IM via a CTRL write acknowledges the flag.
    doReset();
    writeReg(2'd1, 32'd2);
    writeReg(2'd0, 32'h1);
    step(4);
    checkIrq("mask irq", 1'b0);
    step(1);
    checkReg("mask ctrl en cleared", 2'd0, 32'd0);
    writeReg(2'd0, 32'h8);
    checkIrq("mask im set irq", 1'b0);
    step(1);
    checkIrq("mask im later irq", 1'b0);

    // Clearing EN at COUNT=10 freezes the count at 9.
    doReset();
    writeReg(2'd1, 32'd20);
    writeReg(2'd0, 32'h1);
    step(12);
    checkReg("freeze count10", 2'd2, 32'd10);
    writeReg(2'd0, 32'h0);
    checkReg("freeze last dec", 2'd2, 32'd9);
    step(3);
    checkReg("freeze held", 2'd2, 32'd9);

    // PRESET=0 behaves like PRESET=1: irq at edge 3.
    doReset();
    writeReg(2'd0, 32'h9);
    step(2);
    checkIrq("preset0 edge2 irq", 1'b0);
    step(1);
    checkIrq("preset0 edge3 irq", 1'b1);
    checkReg("preset0 count", 2'd2, 32'd0);

    // Largest PRESET: first decrement without wrap.
    doReset();
    writeReg(2'd1, 32'hFFFF_FFFF);
    writeReg(2'd0, 32'h1);
    step(2);
    checkReg("max load", 2'd2, 32'hFFFF_FFFF);
    step(1);
    checkReg("max dec", 2'd2, 32'hFFFF_FFFE);

    // CTRL write in the one-shot INT cycle keeps EN set and restarts counting.
    doReset();
    writeReg(2'd1, 32'd2);
    writeReg(2'd0, 32'h9);
    step(4);
    checkIrq("coll int irq", 1'b1);
    writeReg(2'd0, 32'h9);
    checkReg("coll ctrl keeps en", 2'd0, 32'h9);
    checkIrq("coll ack irq", 1'b0);
    step(2);
    checkReg("coll reload count", 2'd2, 32'd2);
    step(2);
    checkIrq("coll second irq", 1'b1);

    // PRESET write mid-count only affects the next reload.
    doReset();
    writeReg(2'd1, 32'd4);
    writeReg(2'd0, 32'hB);
    step(2);
    checkReg("midp load", 2'd2, 32'd4);
    writeReg(2'd1, 32'd2);
    checkReg("midp count kept", 2'd2, 32'd3);
    step(3);
    checkIrq("midp first irq", 1'b1);
    step(2);
    checkReg("midp new reload", 2'd2, 32'd2);
    step(2);
    checkIrq("midp second irq", 1'b1);

    // A write in the cycle the flag is set must not clear it.
    doReset();
    writeReg(2'd1, 32'd3);
    writeReg(2'd0, 32'h9);
    step(4);
    checkIrq("setwin before", 1'b0);
    writeReg(2'd1, 32'd3);
    checkIrq("setwin same edge", 1'b1);
    step(1);
    checkIrq("setwin held", 1'b1);

    // Randomized bus traffic against the model.
    doReset();
    for (int c = 0; c < 2000; c++) begin
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd0) begin
        d = $urandom;
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      end else if (a == 2'd1) begin
        d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
      end else begin
        d = $urandom;
      end
      applyStimulus(w, a, d);
      ra = 2'($urandom_range(0, 3));
      readReg(ra, rv);
      checkOutput($sformatf("rand c%0d rdata addr%0d", c, ra), rv, modelRead(ra));
      checkIrq($sformatf("rand c%0d irq", c), mIrq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
